// File: rtl/branch_resolve_unit.sv
// Tracks BTB predictions from fetch until EX resolution, emits BTB updates and mispredict redirects.
// Optional performance counters are built only when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  if_hit,
  input  logic [ADDR_WIDTH-1:0] if_pred_target,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic                  upd_taken,
  output logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  perf_branches,
  output logic [CNT_WIDTH-1:0]  perf_mispredicts,
  output logic [CNT_WIDTH-1:0]  perf_btb_hits
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_reg;
  logic [PTR_W-1:0]      head_reg, tail_reg;
  logic [CW-1:0]         count_reg;
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] pred_mem [DEPTH];
  logic [DEPTH-1:0]      hit_mem;

  logic [ADDR_WIDTH-1:0] head_pc, head_pred, pred_next, actual_next;
  logic                  head_hit, resolved_taken, push, pop, mispredict;

  assign if_ready       = (state_reg == RUN) && (count_reg < DEPTH_C);
  assign head_pc        = pc_mem[head_reg];
  assign head_pred      = pred_mem[head_reg];
  assign head_hit       = hit_mem[head_reg];
  assign resolved_taken = ex_is_branch && ex_taken;
  assign pred_next      = head_hit ? head_pred : head_pc + ADDR_WIDTH'(4);
  assign actual_next    = resolved_taken ? ex_target : head_pc + ADDR_WIDTH'(4);
  assign push           = if_valid && if_ready;
  assign pop            = ex_valid && (count_reg != '0) && (state_reg == RUN);
  assign mispredict     = pop && (pred_next != actual_next);

  // Entry storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      pc_mem[tail_reg]   <= if_pc;
      pred_mem[tail_reg] <= if_pred_target;
      hit_mem[tail_reg]  <= if_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RUN;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      underflow_err  <= 1'b0;
    end else begin
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      case (state_reg)
        RUN: begin
          if (ex_valid && (count_reg == '0))
            underflow_err <= 1'b1;
          if (pop) begin
            upd_pc     <= head_pc;
            upd_target <= ex_target;
            upd_taken  <= resolved_taken;
          end
          if (mispredict) begin
            // Everything younger than the mispredicted head is wrong-path, including a same-cycle push.
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            redirect_pc    <= actual_next;
            redirect_valid <= 1'b1;
            state_reg      <= FLUSH;
          end else begin
            if (push) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)  head_reg <= head_reg + PTR_W'(1);
            if (push && !pop)
              count_reg <= count_reg + CW'(1);
            else if (pop && !push)
              count_reg <= count_reg - CW'(1);
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] branches_reg, mispredicts_reg, hits_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
      hits_reg        <= '0;
    end else if (pop) begin
      if (ex_is_branch && (branches_reg != '1))
        branches_reg <= branches_reg + CNT_WIDTH'(1);
      if (mispredict && (mispredicts_reg != '1))
        mispredicts_reg <= mispredicts_reg + CNT_WIDTH'(1);
      if (head_hit && (hits_reg != '1))
        hits_reg <= hits_reg + CNT_WIDTH'(1);
    end
  end

  assign perf_branches    = branches_reg;
  assign perf_mispredicts = mispredicts_reg;
  assign perf_btb_hits    = hits_reg;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
  assign perf_btb_hits    = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference queue predicts each resolution's update/redirect.
module tb_branch_resolve_unit;
  logic        clk, reset;
  logic        if_valid, if_ready, if_hit;
  logic [63:0] if_pc, if_pred_target;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic [63:0] ex_target;
  logic [63:0] upd_pc, upd_target, redirect_pc;
  logic        upd_taken, redirect_valid, underflow_err;
  logic [31:0] perf_branches, perf_mispredicts, perf_btb_hits;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_hit(if_hit),
    .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .underflow_err(underflow_err),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts), .perf_btb_hits(perf_btb_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; bit hit; logic [63:0] pred; } ent_t;
  typedef struct { logic [63:0] pc; bit taken; logic [63:0] tgt; bit redir; logic [63:0] rpc; } exp_t;

  ent_t  mq[$];
  exp_t  exp_q[$];
  bit    flush_m, uf_m;
  logic [63:0] last_pc, last_tgt, last_rpc;
  int    pb_m, pm_m, ph_m;
  int    checks = 0;
  int    failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete(); exp_q.delete();
    flush_m = 0; uf_m = 0;
    last_pc = '0; last_tgt = '0; last_rpc = '0;
    pb_m = 0; pm_m = 0; ph_m = 0;
  endtask

  // Reset is raised between edges so its asynchronous effect is observed before any clock.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_eq("rst_if_ready", if_ready, 1);
    check_eq("rst_upd_taken", upd_taken, 0);
    check_eq("rst_redirect_valid", redirect_valid, 0);
    check_eq("rst_underflow", underflow_err, 0);
    check_eq("rst_upd_pc", upd_pc, 0);
    check_eq("rst_redirect_pc", redirect_pc, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic cycle(input bit push, input logic [63:0] pc, input bit hit, input logic [63:0] pred,
                       input bit pop, input bit br, input bit tk, input logic [63:0] tgt);
    ent_t e; exp_t x; bit rdy, misp, exp_taken, exp_redir;
    logic [63:0] pn, an;
    rdy  = !flush_m && (mq.size() < 4);
    misp = 0;
    check_eq("if_ready", if_ready, rdy);
    if_valid = push; if_pc = pc; if_hit = hit; if_pred_target = pred;
    ex_valid = pop; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
    if (pop && !flush_m && mq.size() == 0) uf_m = 1;
    if (pop && !flush_m && mq.size() != 0) begin
      e  = mq.pop_front();
      pn = e.hit ? e.pred : e.pc + 64'd4;
      an = (br && tk) ? tgt : e.pc + 64'd4;
      misp = (pn != an);
      x = '{e.pc, br && tk, tgt, misp, an};
      exp_q.push_back(x);
      if (br) pb_m++;
      if (misp) pm_m++;
      if (e.hit) ph_m++;
    end
    if (misp) mq.delete();
    else if (push && rdy) mq.push_back('{pc, hit, pred});
    @(posedge clk); #1;
    if_valid = 0; ex_valid = 0;
    flush_m = misp;
    exp_taken = 0; exp_redir = 0;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      last_pc = x.pc; last_tgt = x.tgt;
      exp_taken = x.taken; exp_redir = x.redir;
      if (x.redir) last_rpc = x.rpc;
      $display("pop pc=%0h taken=%0b tgt=%0h redir=%0b", x.pc, x.taken, x.tgt, x.redir);
    end
    check_eq("upd_taken", upd_taken, exp_taken);
    check_eq("upd_pc", upd_pc, last_pc);
    check_eq("upd_target", upd_target, last_tgt);
    check_eq("redirect_valid", redirect_valid, exp_redir);
    check_eq("redirect_pc", redirect_pc, last_rpc);
    check_eq("underflow_err", underflow_err, uf_m);
  endtask

  task automatic check_perf(input int b, input int m, input int h);
`ifdef BRU_PERF_CNT_EN
    check_eq("perf_branches", perf_branches, b);
    check_eq("perf_mispredicts", perf_mispredicts, m);
    check_eq("perf_btb_hits", perf_btb_hits, h);
`else
    check_eq("perf_branches", perf_branches, 0);
    check_eq("perf_mispredicts", perf_mispredicts, 0);
    check_eq("perf_btb_hits", perf_btb_hits, 0);
`endif
  endtask

  initial begin
    reset = 0; if_valid = 0; if_pc = 0; if_hit = 0; if_pred_target = 0;
    ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Non-branch, no hit: plain fall-through update.
    cycle(1, 64'h1000, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 64'h0);
    check_eq("t1_upd_pc", upd_pc, 64'h1000);

    // Correctly predicted taken branch.
    cycle(1, 64'h2000, 1, 64'h3000, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1, 64'h3000);
    check_eq("t2_upd_target", upd_target, 64'h3000);

    // Mispredict flushes younger entries; ex_valid during FLUSH is ignored.
    cycle(1, 64'h100, 0, 0, 0, 0, 0, 0);
    cycle(1, 64'h104, 0, 0, 0, 0, 0, 0);
    cycle(1, 64'h108, 0, 0, 0, 0, 0, 0);
    cycle(1, 64'h10c, 0, 0, 1, 1, 1, 64'h400);
    check_eq("t3_redirect_pc", redirect_pc, 64'h400);
    check_eq("t3_flush_if_ready", if_ready, 0);
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Fill to DEPTH, then a push alongside a pop must be refused.
    for (int i = 0; i < 4; i++) cycle(1, 64'h200 + 64'(4 * i), 0, 0, 0, 0, 0, 0);
    check_eq("t4_full_if_ready", if_ready, 0);
    cycle(1, 64'h2f0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("t4_drained_upd_pc", upd_pc, 64'h20c);

    // Wrap: simultaneous push/pop walks pointers around the ring.
    cycle(1, 64'h5000, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cycle(1, 64'h5000 + 64'(4 * i), 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("t4_wrap_last_pc", upd_pc, 64'h5028);

    // Underflow is sticky until reset.
    cycle(0, 0, 0, 0, 1, 1, 1, 64'h9000);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_underflow_sticky", underflow_err, 1);
    do_reset();

    // Perf counters: 3 branches, 1 mispredict, 2 hits.
    cycle(1, 64'h600, 1, 64'h640, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1, 64'h640);
    cycle(1, 64'h640, 1, 64'h680, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1, 64'h680);
    cycle(1, 64'h680, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1, 64'h800);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_perf(3, 1, 2);
    check_perf(pb_m, pm_m, ph_m);

    // Reset during FLUSH aborts it and empties the queue.
    cycle(1, 64'h700, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1, 64'h900);
    do_reset();
    check_perf(0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every fetched instruction's BTB prediction from the IF stage until it resolves in the EX stage. It then produces the BTB update stream (`upd_pc`, `upd_taken`, `upd_target`) and a front-end redirect on mispredict. It sits between the fetch stage and the BTB/PC-select logic and is the write-side producer for the BTB's EX-stage update port. In-flight predictions are held in an in-order queue, and the queue is flushed on mispredict.

## Interface
- `ADDR_WIDTH`, default 64: address width.
- `DEPTH`, default 4: in-flight queue entries; must be a power of two and ≥ 2.
- `CNT_WIDTH`, default 32: width of the performance counters.

- `clk`: input, 1 bit. The single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `if_valid`: input, 1 bit. A fetched instruction is presented.
- `if_ready`: output, 1 bit. The queue can accept an entry.
- `if_pc`: input, `ADDR_WIDTH` bits. Fetch PC.
- `if_hit`: input, 1 bit. BTB hit for `if_pc`.
- `if_pred_target`: input, `ADDR_WIDTH` bits. BTB predicted target.
- `ex_valid`: input, 1 bit. The oldest in-flight instruction resolves this cycle.
- `ex_is_branch`: input, 1 bit. The resolving instruction is a branch or jump.
- `ex_taken`: input, 1 bit. The branch resolved as taken.
- `ex_target`: input, `ADDR_WIDTH` bits. Resolved branch target.
- `upd_pc`: output, `ADDR_WIDTH` bits. PC of the resolved instruction, sent to the BTB.
- `upd_taken`: output, 1 bit. Single-cycle pulse; the BTB writes its entry on this.
- `upd_target`: output, `ADDR_WIDTH` bits. Target to write into the BTB.
- `redirect_valid`: output, 1 bit. Single-cycle pulse; fetch must restart at `redirect_pc`.
- `redirect_pc`: output, `ADDR_WIDTH` bits. Correct next PC.
- `underflow_err`: output, 1 bit. Sticky; set when `ex_valid` arrives while the queue is empty.
- `perf_branches`, `perf_mispredicts`, `perf_btb_hits`: outputs, `CNT_WIDTH` bits each. Performance counters.

## Operation
- The queue is a circular buffer with `DEPTH` entries, each holding `{pc, hit, pred_target}`. It has head and tail pointers plus a count of width `$clog2(DEPTH)+1`.
- Push: occurs when `if_valid && if_ready`. `if_ready = (state==RUN) && (count < DEPTH)`.
- Pop: occurs when `ex_valid && count != 0 && state==RUN`, and removes the head entry. A push and a pop in the same cycle leave the count unchanged.
- Predicted next PC: `hit ? pred_target : pc + 4`.
- Actual next PC: `(ex_is_branch && ex_taken) ? ex_target : pc + 4`.
- All additions are modulo 2^`ADDR_WIDTH`, so `pc + 4` wraps.
- Mispredict is defined as predicted next PC ≠ actual next PC.
- On every pop:
  - `upd_pc` is set to the head `pc`.
  - `upd_target` is set to `ex_target`.
  - `upd_taken` is set to `ex_is_branch && ex_taken`.
- The FSM has two states:
  - **RUN**: normal operation. A pop with mispredict does the following:
    - clears the queue: head = tail = 0, count = 0, and any same-cycle push is discarded;
    - latches `redirect_pc` = actual next PC;
    - enters FLUSH.
  - **FLUSH**: lasts exactly one cycle.
    - `redirect_valid` is 1.
    - `if_ready` is 0.
    - `ex_valid` is ignored: no pop, no update, and `underflow_err` is not set.
    - The next state is RUN.
- `ex_valid` with an empty queue in RUN is a no-op except that it sets `underflow_err`. `underflow_err` is cleared only by reset.

## Timing
- Reset values:
  - `if_ready` = 1.
  - `upd_taken`, `redirect_valid`, `underflow_err` = 0.
  - `upd_pc`, `upd_target`, `redirect_pc` = 0.
  - All counters = 0.
  - count = 0; state = RUN.
- Reset asserted mid-operation empties the queue immediately and aborts any FLUSH.
- `if_ready` is combinational from state and count only. It never depends on `if_valid` or `ex_valid`, so a full queue does not accept a push even when a pop happens in the same cycle.
- BTB update outputs are registered, with 1-cycle latency. A pop at edge N makes `upd_*` valid for the cycle after edge N. `upd_taken` is 0 in every other cycle; `upd_pc` and `upd_target` hold their last value.
- Redirect latency: a mispredicting pop at edge N drives `redirect_valid` high for exactly the cycle after edge N, together with `upd_taken` for the same instruction.
- Back-to-back pops are supported every cycle in RUN.

## Configuration
- `BRU_PERF_CNT_EN`:
  - **Defined:** on each pop the counters update as follows, all saturating at all-ones:
    - `perf_branches` increments when `ex_is_branch`;
    - `perf_mispredicts` increments on mispredict;
    - `perf_btb_hits` increments when the head `hit` is 1.
  - **Undefined:** no counter registers are built, and all three `perf_*` outputs are tied to 0.

## Test plan
- Reset, then push PC 0x1000 with `if_hit`=0 and pop it with `ex_is_branch`=0. Required: `upd_taken`=0, `upd_pc`=0x1000, `redirect_valid`=0.
- Push PC 0x2000 with hit=1 and `pred_target`=0x3000, then pop it taken with `ex_target`=0x3000. Required: `upd_taken`=1, `upd_target`=0x3000, no redirect.
- Push PCs 0x100, 0x104, 0x108, then pop 0x100 taken to 0x400 while it was predicted not-hit. Required:
  - next cycle, `redirect_valid`=1 with `redirect_pc`=0x400 and `upd_taken`=1;
  - `if_ready`=0 during that cycle;
  - count=0 afterwards.
- Push 4 entries with `DEPTH`=4. Required: `if_ready`=0. A simultaneous push and pop does not accept the push. Wrap test: 10 push/pop pairs return PCs in FIFO order.
- `ex_valid` with the queue empty. Required: `underflow_err`=1 and it stays set; pulse `reset` and it returns to 0.
- With `BRU_PERF_CNT_EN` defined, run 3 branches (1 mispredict, 2 BTB hits). Required: counters read 3 / 1 / 2. Without the macro, all counters read 0.
